sar_adc_ctrl: RTL and testbench

Successive-approximation ADC controller that closes the loop around the team's digital OTA/comparator. It drives a binary-weighted DAC code to the off-block R-2R ladder, reads back the comparator decision, and resolves one bit per step, MSB first. The block sits beside the comparator in the analog tile wrapper: `dac_code` goes out on dedicated outputs, and `cmp_in` comes back from the comparator output pin.

---
 rtl/sar_adc_pkg.sv | 7 +
 rtl/sync_2ff.sv | 18 +
 rtl/sar_adc_ctrl.sv | 96 +++++++++
 tb/tb_sar_adc_ctrl.sv | 131 +++++++++++++
 4 files changed

// File: rtl/sar_adc_pkg.sv
// sar_adc_pkg: shared state encoding and parameter limits for the SAR ADC controller
package sar_adc_pkg;
  typedef enum logic [1:0] {S_IDLE, S_TRACK, S_CONVERT, S_DONE} state_t;
  localparam int WIDTH_MIN  = 4;
  localparam int WIDTH_MAX  = 12;
  localparam int SETTLE_MIN = 3;
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: 1-bit two-flop synchronizer with asynchronous active-high reset
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);
  logic r_meta;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta <= 1'b0;
      o_q    <= 1'b0;
    end else begin
      r_meta <= i_d;
      o_q    <= r_meta;
    end
  end
endmodule

// File: rtl/sar_adc_ctrl.sv
// sar_adc_ctrl: successive-approximation controller driving a DAC code, MSB first
module sar_adc_ctrl
  import sar_adc_pkg::*;
#(
  parameter int WIDTH         = 8,
  parameter int TRACK_CYCLES  = 4,
  parameter int SETTLE_CYCLES = 4,
  parameter bit COMP_INVERT   = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             cmp_in,
  output logic [WIDTH-1:0] dac_code,
  output logic             sample_hold,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);
  localparam int CMAX = (TRACK_CYCLES > SETTLE_CYCLES) ? TRACK_CYCLES : SETTLE_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);
  localparam int IW   = $clog2(WIDTH);

  state_t           r_state, w_state_nx;
  logic [CW-1:0]    r_cnt, w_cnt_nx;
  logic [IW-1:0]    r_idx, w_idx_nx;
  logic [WIDTH-1:0] r_sar, w_sar_nx, w_dec, w_result_nx;
  logic             w_sync, w_cmp;

  sync_2ff u_sync (.clk(clk), .rst(rst), .i_d(cmp_in), .o_q(w_sync));

  assign w_cmp = w_sync ^ COMP_INVERT;
  // keep bits above the current index, place the decision, clear everything below
  assign w_dec = (r_sar & (({WIDTH{1'b1}} << r_idx) << 1)) | (WIDTH'(w_cmp) << r_idx);

  always_comb begin
    w_state_nx  = r_state;
    w_cnt_nx    = r_cnt + 1'b1;
    w_idx_nx    = r_idx;
    w_sar_nx    = r_sar;
    w_result_nx = result;
    unique case (r_state)
      S_IDLE: begin
        w_state_nx = start ? S_TRACK : S_IDLE;
        w_cnt_nx   = '0;
      end
      S_TRACK:
        if (r_cnt == CW'(TRACK_CYCLES - 1)) begin
          w_state_nx = S_CONVERT;
          w_cnt_nx   = '0;
          w_idx_nx   = IW'(WIDTH - 1);
          w_sar_nx   = '0;
        end
      S_CONVERT:
        if (r_cnt == CW'(SETTLE_CYCLES - 1)) begin
          w_sar_nx = w_dec;
          w_cnt_nx = '0;
          if (r_idx == '0) begin
            w_state_nx  = S_DONE;
            w_result_nx = w_dec;
          end else begin
            w_idx_nx = r_idx - 1'b1;
          end
        end
      default: begin
        w_state_nx = start ? S_TRACK : S_IDLE;
        w_cnt_nx   = '0;
      end
    endcase
  end

  // outputs are registered from the next-state view so they align with the state they describe
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_idx       <= '0;
      r_sar       <= '0;
      dac_code    <= '0;
      sample_hold <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      result      <= '0;
    end else begin
      r_state     <= w_state_nx;
      r_cnt       <= w_cnt_nx;
      r_idx       <= w_idx_nx;
      r_sar       <= w_sar_nx;
      dac_code    <= (w_state_nx == S_CONVERT) ? (w_sar_nx | (WIDTH'(1) << w_idx_nx)) : '0;
      sample_hold <= w_state_nx == S_TRACK;
      busy        <= (w_state_nx == S_TRACK) || (w_state_nx == S_CONVERT);
      done        <= w_state_nx == S_DONE;
      result      <= w_result_nx;
    end
  end
endmodule

// File: tb/tb_sar_adc_ctrl.sv
// tb_sar_adc_ctrl: directed and randomized checks of sar_adc_ctrl against a binary-search model
module tb_sar_adc_ctrl;
  logic       clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [7:0] thr = 8'h5A;
  int         mode = 0;
  logic [7:0] dac_a, res_a, dac_b, res_b;
  logic       sh_a, busy_a, done_a, sh_b, busy_b, done_b, cmp_a, cmp_b;
  int         tests = 0, fails = 0;
  logic [7:0] exp_res = 8'h00;

  // mode 0: ideal comparator against thr; mode 1: tied high; mode 2: tied low
  assign cmp_a = (mode == 0) ? (thr >= dac_a) : (mode == 1);
  assign cmp_b = (mode == 0) ? !(thr >= dac_b) : (mode != 1);

  sar_adc_ctrl u_dut (
    .clk(clk), .rst(rst), .start(start), .cmp_in(cmp_a), .dac_code(dac_a),
    .sample_hold(sh_a), .busy(busy_a), .done(done_a), .result(res_a)
  );
  sar_adc_ctrl #(.COMP_INVERT(1'b1)) u_inv (
    .clk(clk), .rst(rst), .start(start), .cmp_in(cmp_b), .dac_code(dac_b),
    .sample_hold(sh_b), .busy(busy_b), .done(done_b), .result(res_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_both(input string tag, input logic [18:0] expv);
    chk({tag, " dut"}, {13'd0, sh_a, busy_a, done_a, dac_a, res_a}, {13'd0, expv});
    chk({tag, " inv"}, {13'd0, sh_b, busy_b, done_b, dac_b, res_b}, {13'd0, expv});
  endtask

  // one conversion: start sampled at the first edge (k); cycles k+1..k+37 are checked
  task automatic conv(input string name, input int mid, input bit hold);
    logic [7:0] seq [8];
    logic [7:0] s = 8'h00;
    logic [7:0] d;
    int c;
    for (int n = 0; n < 8; n++) begin
      seq[n] = s | (8'h80 >> n);
      if ((mode == 0) ? (thr >= seq[n]) : (mode == 1)) s = seq[n];
    end
    start = 1'b1;
    tick();
    for (int j = 0; j <= 36; j++) begin
      if (j > 0) begin
        start = hold || (j == mid);
        tick();
      end
      c = j + 1;
      d = (c > 4 && c <= 36) ? seq[(c - 5) / 4] : 8'h00;
      if (c == 37) exp_res = s;
      chk_both($sformatf("%s c%0d", name, c), {c <= 4, c <= 36, c == 37, d, exp_res});
    end
  endtask

  task automatic idle_chk(input string name);
    start = 1'b0;
    tick();
    chk_both({name, " idle"}, {3'b000, 8'h00, exp_res});
  endtask

  initial begin
    tick();
    tick();
    chk_both("reset", 19'd0);
    rst = 1'b0;
    tick();
    chk_both("post reset idle", 19'd0);

    mode = 0; thr = 8'h5A;
    conv("model5A", -1, 1'b0);
    idle_chk("model5A");
    chk("model5A value", {24'd0, exp_res}, 32'h5A);

    mode = 1;
    conv("tie1", -1, 1'b0);
    idle_chk("tie1");
    mode = 2;
    conv("tie0", -1, 1'b0);
    idle_chk("tie0");

    mode = 0;
    for (int r = 0; r < 4; r++) begin
      thr = 8'($urandom_range(0, 255));
      conv($sformatf("rand%0d_%02h", r, thr), -1, 1'b0);
      idle_chk("rand");
    end

    thr = 8'h5A;
    conv("midstart", 10, 1'b0);
    idle_chk("midstart");

    conv("b2b_1", -1, 1'b1);
    thr = 8'hC3;
    conv("b2b_2", -1, 1'b1);
    idle_chk("b2b");

    thr = 8'h5A;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (19) tick();
    rst = 1'b1;
    #1;
    exp_res = 8'h00;
    chk_both("async reset", 19'd0);
    tick();
    tick();
    rst = 1'b0;
    repeat (3) tick();
    chk_both("after reset", 19'd0);
    thr = 8'hA7;
    conv("post_rst", -1, 1'b0);
    idle_chk("post_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
